pll_reset_ctrl: RTL and testbench
=================================

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

Interface
REQ-001 SHALL have parameter RST_PULSE_CYC, default 16: refclk cycles that pll_rst is held high per reset pulse.
REQ-002 SHALL have parameter LOCK_STABLE_CYC, default 1024: consecutive synchronized-lock cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYC, default 65535: maximum refclk cycles spent waiting for lock per attempt.
REQ-004 SHALL have parameter MAX_RETRY, default 3: failed lock attempts before entering FAULT.
REQ-005 SHALL have port refclk, input, 1: the single clock (PLL reference clock).
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pll_locked, input, 1: PLL locked flag, asynchronous to refclk.
REQ-008 SHALL have port relock_req, input, 1: synchronous level request to restart the sequence.
REQ-009 SHALL have port pll_rst, output, 1: active-high reset driving the PLL rst input.
REQ-010 SHALL have port sys_rst_n, output, 1: active-low downstream reset release, synchronous to refclk.
REQ-011 SHALL have port ready, output, 1: high only in state RUN.
REQ-012 SHALL have port fault, output, 1: high only in state FAULT.
REQ-013 SHALL have port retry_cnt, output, $clog2(MAX_RETRY+1): failed attempts since the last rst_n or relock_req.

Function
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer (lock_s); all decisions use lock_s (2-cycle latency).
REQ-015 SHALL implement states RESET, WAIT_LOCK, STABLE, RUN and FAULT, using one shared cycle counter sized for the largest parameter.
REQ-016 RESET: pll_rst=1; counter counts RST_PULSE_CYC cycles, then -> WAIT_LOCK with counter cleared.
REQ-017 WAIT_LOCK: pll_rst=0; lock_s=1 -> STABLE with counter cleared; after LOCK_TIMEOUT_CYC cycles without lock_s, retry_cnt increments, then -> FAULT if new value==MAX_RETRY, else -> RESET.
REQ-018 STABLE: lock_s=0 -> WAIT_LOCK with counter cleared and retry_cnt unchanged; LOCK_STABLE_CYC consecutive lock_s=1 cycles -> RUN.
REQ-019 RUN: sys_rst_n=1, ready=1, registered; both rise the cycle after STABLE completes.
REQ-020 RUN lock_s=0 behaviour SHALL follow REQ-027/REQ-028; sys_rst_n and ready fall on the cycle RUN is exited.
REQ-021 FAULT: pll_rst=1, sys_rst_n=0, fault=1; the state is sticky until rst_n or relock_req.
REQ-022 relock_req=1 in any state -> RESET next cycle with retry_cnt cleared; it takes priority over a simultaneous timeout or lock event.
REQ-023 retry_cnt SHALL saturate at MAX_RETRY.
REQ-024 sys_rst_n SHALL be 0 in every state except RUN, and pll_rst SHALL be 1 only in RESET and FAULT.

Reset
REQ-025 While rst_n=0, all outputs SHALL take their reset values immediately: pll_rst=1, sys_rst_n=0, ready=0, fault=0, retry_cnt=0, state=RESET, counter=0, synchronizer=0.
REQ-026 On rst_n deassertion, the RESET pulse SHALL last exactly RST_PULSE_CYC cycles.

Configuration
REQ-027 With PLL_RESET_CTRL_LOSS_RECOVER_EN defined, lock_s=0 in RUN -> RESET (automatic re-lock), with retry_cnt cleared.
REQ-028 Without PLL_RESET_CTRL_LOSS_RECOVER_EN defined, lock_s=0 in RUN -> FAULT.

Structure
REQ-029 Package pll_ctrl_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-030 The synchronizer SHALL be the sub-module pll_lock_sync (2-flop, async active-low clear); the FSM and counters SHALL live in pll_reset_ctrl.

Verification (RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRY=2)
REQ-031 Bring-up: rst_n releases at cycle 0 and pll_locked rises at cycle 10 -> pll_rst falls at cycle 4; sys_rst_n and ready rise at cycle 21.
REQ-032 Glitch: pll_locked low for 1 cycle after 5 STABLE cycles -> return to WAIT_LOCK; ready rises 8 lock_s cycles after recovery; retry_cnt=0.
REQ-033 Timeout: pll_locked held 0 -> pll_rst re-pulses at cycle 36 with retry_cnt=1; at cycle 72 fault=1, retry_cnt=2, pll_rst held 1.
REQ-034 Lock loss in RUN -> ready falls 3 cycles after pll_locked falls; with the macro, pll_rst pulses for 4 cycles; without the macro, fault=1.
REQ-035 relock_req=1 for 1 cycle in FAULT -> fault=0, retry_cnt=0, 4-cycle pll_rst pulse; relock_req in the same cycle as a timeout -> retry_cnt=0.
REQ-036 rst_n asserted mid-STABLE -> all outputs reach reset values without a refclk edge; release -> a full 4-cycle RESET pulse.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } pll_state_e;

  localparam int DEF_RST_PULSE_CYC    = 16;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYC = 65535;
  localparam int DEF_MAX_RETRY        = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into refclk.
module pll_lock_sync (
  input  logic refclk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset/lock sequencer with bounded retries and a sticky fault state.
// Define PLL_RESET_CTRL_LOSS_RECOVER_EN to re-run the sequence on lock loss in RUN instead of faulting.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic                           refclk,
  input  logic                           rst_n,
  input  logic                           pll_locked,
  input  logic                           relock_req,
  output logic                           pll_rst,
  output logic                           sys_rst_n,
  output logic                           ready,
  output logic                           fault,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int CNT_W   = $clog2(max3(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC) + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  logic lock_s;

  pll_lock_sync u_lock_sync (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .async_in (pll_locked),
    .sync_out (lock_s)
  );

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;

    // A relock request overrides whatever the current state would have done.
    if (relock_req) begin
      state_d = ST_RESET;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_RESET;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
`ifdef PLL_RESET_CTRL_LOSS_RECOVER_EN
            state_d = ST_RESET;
            retry_d = '0;
`else
            state_d = ST_FAULT;
`endif
            cnt_d = '0;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow the next state so they change on the same edge as the state.
    pll_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAULT);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl: random lock timing checked against a timeline model.
module tb_pll_reset_ctrl;

  localparam int RST = 4;
  localparam int STB = 8;
  localparam int TO  = 32;
  localparam int MR  = 2;

  logic       refclk     = 1'b0;
  logic       rst_n      = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [5:0] obs;

  int cyc;
  int n_checks;
  int n_fail;

  assign obs = {pll_rst, sys_rst_n, ready, fault, retry_cnt};

  pll_reset_ctrl #(
    .RST_PULSE_CYC    (RST),
    .LOCK_STABLE_CYC  (STB),
    .LOCK_TIMEOUT_CYC (TO),
    .MAX_RETRY        (MR)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
  );

  always #5 refclk = ~refclk;

  // Timeline model: cycle c is the interval after the c-th rising edge since rst_n release,
  // with pll_locked high from cycle lock_at onwards. Returns {pll_rst,sys_rst_n,ready,fault,retry}.
  function automatic logic [5:0] model_bringup(input int lock_at, input int c);
    int seen, start, last, rdy_at, flt_at, tos, n_to;
    int to_edge[MR];
    bit found, prst, rdy, flt;
    seen   = lock_at + 3;
    rdy_at = -1;
    flt_at = -1;
    n_to   = 0;
    found  = 1'b0;
    for (int k = 0; k < MR; k++) begin
      to_edge[k] = 0;
      if (!found) begin
        start = RST + 1 + k * (RST + TO);
        last  = start + TO - 1;
        if (seen <= last) begin
          found  = 1'b1;
          rdy_at = ((seen > start) ? seen : start) + STB;
        end else begin
          to_edge[n_to] = last;
          n_to++;
        end
      end
    end
    if (n_to == MR) flt_at = to_edge[MR-1];
    tos  = 0;
    prst = (c < RST);
    for (int k = 0; k < n_to; k++) begin
      if (c >= to_edge[k]) tos++;
      if (k < MR - 1 && c >= to_edge[k] && c < to_edge[k] + RST) prst = 1'b1;
    end
    flt = (flt_at >= 0) && (c >= flt_at);
    if (flt) prst = 1'b1;
    rdy = (rdy_at >= 0) && (c >= rdy_at);
    return {prst, rdy, rdy, flt, 2'(tos)};
  endfunction

  task automatic step();
    @(posedge refclk);
    @(negedge refclk);
    cyc++;
  endtask

  task automatic release_from_reset(input logic lock_lvl);
    rst_n      = 1'b0;
    relock_req = 1'b0;
    pll_locked = lock_lvl;
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b", obs, 6'b100000);
    end
    repeat (3) @(negedge refclk);
    n_checks++;
    if (obs !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected %b", obs, 6'b100000);
    end
    $display("reset: outputs checked while rst_n low");
  endtask

  task automatic test_bringup(input int lock_at, input int ncyc);
    logic [5:0] exp;
    release_from_reset(1'b0);
    for (int c = 0; c <= ncyc; c++) begin
      pll_locked = (c >= lock_at);
      exp = model_bringup(lock_at, c);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL bringup lock_at=%0d cycle=%0d: got %b expected %b", lock_at, cyc, obs, exp);
      end
      step();
    end
    $display("bringup: lock_at=%0d cycles=%0d", lock_at, ncyc);
  endtask

  task automatic test_glitch(input int g);
    logic [5:0] exp;
    int rdy_at;
    rdy_at = g + 4 + STB;
    release_from_reset(1'b0);
    for (int c = 0; c <= 40; c++) begin
      pll_locked = (c >= 10) && (c != g);
      exp = {(c < RST), (c >= rdy_at), (c >= rdy_at), 1'b0, 2'b00};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL glitch g=%0d cycle=%0d: got %b expected %b", g, cyc, obs, exp);
      end
      step();
    end
    $display("glitch: lock low at cycle %0d, ready expected at %0d", g, rdy_at);
  endtask

  task automatic test_lock_loss(input int d);
    logic [5:0] exp;
    int exit_c;
    exit_c = d + 3;
    release_from_reset(1'b0);
    for (int c = 0; c <= d + 14; c++) begin
      pll_locked = (c >= 10) && (c < d);
      if (c < exit_c) exp = model_bringup(10, c);
`ifdef PLL_RESET_CTRL_LOSS_RECOVER_EN
      else exp = {(c < exit_c + RST), 1'b0, 1'b0, 1'b0, 2'b00};
`else
      else exp = 6'b100100;
`endif
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL lock_loss d=%0d cycle=%0d: got %b expected %b", d, cyc, obs, exp);
      end
      step();
    end
    $display("lock_loss: pll_locked fell at cycle %0d", d);
  endtask

  task automatic test_relock(input int lock_at, input int r, input int ncyc);
    logic [5:0] exp;
    release_from_reset(1'b0);
    for (int c = 0; c <= ncyc; c++) begin
      pll_locked = (c >= lock_at);
      relock_req = (c == r);
      exp = (c <= r) ? model_bringup(lock_at, c) : model_bringup(lock_at, c - r - 1);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL relock lock_at=%0d r=%0d cycle=%0d: got %b expected %b", lock_at, r, cyc, obs, exp);
      end
      step();
    end
    relock_req = 1'b0;
    $display("relock: lock_at=%0d relock_req at cycle %0d", lock_at, r);
  endtask

  task automatic test_async_reset();
    logic [5:0] exp;
    release_from_reset(1'b0);
    for (int c = 0; c < 16; c++) begin
      pll_locked = (c >= 10);
      exp = model_bringup(10, c);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL async_pre cycle=%0d: got %b expected %b", cyc, obs, exp);
      end
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 6'b100000) begin
      n_fail++;
      $display("FAIL async_mid_stable: got %b expected %b", obs, 6'b100000);
    end
    @(negedge refclk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int c = 0; c <= 25; c++) begin
      exp = model_bringup(0, c);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL async_release cycle=%0d: got %b expected %b", cyc, obs, exp);
      end
      step();
    end
    $display("async_reset: asserted mid-STABLE and released with lock held");
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_bringup(10, 30);
    test_bringup(1000, 90);
    repeat (6) test_bringup(int'($urandom_range(0, 80)), 100);
    test_glitch(11);
    test_glitch(18);
    repeat (2) test_glitch(int'($urandom_range(11, 18)));
    repeat (3) test_lock_loss(int'($urandom_range(22, 30)));
    test_relock(1000, 35, 60);
    test_relock(1000, 80, 130);
    test_relock(0, int'($urandom_range(14, 30)), 70);
    test_relock(1000, int'($urandom_range(0, 100)), 150);
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
